// File: rtl/binarize_pkg.sv
// Shared types and constants for the adaptive-threshold binarizer.
// Pixel/sum widths, FSM encoding and the threshold clamp helper.
package binarize_pkg;

   localparam int PIX_W = 12;
   localparam int SUM_W = 32;
   localparam int OFF_W = 10;
   localparam int CAND_W = 14;
   localparam int CNT_W_DEF = 20;
   localparam logic [PIX_W-1:0] DEFAULT_THR_DEF = 12'd3747;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DIVIDE,
      ST_UPDATE
   } state_e;

   // Saturate a signed candidate into the unsigned pixel range.
   function automatic logic [PIX_W-1:0] clamp_thr(
      input logic [CAND_W-1:0] v
   );
      logic [PIX_W-1:0] r;
      if (v[CAND_W-1])
         r = '0;
      else if (|v[CAND_W-2:PIX_W])
         r = '1;
      else
         r = v[PIX_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Fixed latency: oDONE pulses N_W cycles after the iSTART edge.
module seq_divider
   import binarize_pkg::*;
#(
   parameter int N_W = SUM_W,
   parameter int D_W = CNT_W_DEF
) (
   input  logic           iCLK,
   input  logic           iRST,
   input  logic           iSTART,
   input  logic [N_W-1:0] iNUM,
   input  logic [D_W-1:0] iDEN,
   output logic           oDONE,
   output logic [N_W-1:0] oQUO
);

   localparam int STEP_W = $clog2(N_W);

   logic [N_W-1:0]    quo_q, quo_d;
   logic [D_W-1:0]    rem_q, rem_d;
   logic [D_W-1:0]    den_q, den_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              run_q, run_d;
   logic              done_q, done_d;
   logic [D_W:0]      trial;
   logic [D_W:0]      diff;
   logic              qbit;

   // One shift-subtract step per cycle while running.
   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      den_d  = den_q;
      step_d = step_q;
      run_d  = run_q;
      done_d = 1'b0;
      trial  = {rem_q, quo_q[N_W-1]};
      diff   = trial - {1'b0, den_q};
      qbit   = (trial >= {1'b0, den_q});
      if (iSTART) begin
         quo_d  = iNUM;
         rem_d  = '0;
         den_d  = iDEN;
         step_d = '0;
         run_d  = 1'b1;
      end else if (run_q) begin
         rem_d  = qbit ? diff[D_W-1:0] : trial[D_W-1:0];
         quo_d  = {quo_q[N_W-2:0], qbit};
         step_d = step_q + STEP_W'(1);
         if (step_q == STEP_W'(N_W - 1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state registers.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         quo_q  <= '0;
         rem_q  <= '0;
         den_q  <= '0;
         step_q <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         den_q  <= den_d;
         step_q <= step_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign oDONE = done_q;
   assign oQUO  = quo_q;

endmodule

// File: rtl/threshold_ctrl.sv
// Binarizer threshold controller: manual value or frame mean + offset.
// Threshold only changes during blanking so a frame sees one value.
module threshold_ctrl
   import binarize_pkg::*;
#(
   parameter logic [PIX_W-1:0] DEFAULT_THR = DEFAULT_THR_DEF,
   parameter int               CNT_W       = CNT_W_DEF
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iFVAL,
   input  logic             iDVAL,
   input  logic [PIX_W-1:0] iDATA,
   input  logic             iMODE,
   input  logic [PIX_W-1:0] iMAN_THR,
   input  logic [OFF_W-1:0] iOFFSET,
   output logic [PIX_W-1:0] oTHRESHOLD,
   output logic             oTHR_VALID,
   output logic             oBUSY,
   output logic             oOVF
);

   state_e             state_q, state_d;
   logic               fval_q;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [PIX_W-1:0]   thr_q, thr_d;
   logic               vld_q, vld_d;
   logic               pend_q, pend_d;
   logic [PIX_W-1:0]   pthr_q, pthr_d;

   logic               fstart;
   logic               fend;
   logic               pix;
   logic               div_start;
   logic               div_done;
   logic [SUM_W-1:0]   quo;
   logic               cand_rdy;
   logic [PIX_W-1:0]   mean;
   logic [CAND_W-1:0]  cand_s;
   logic [PIX_W-1:0]   cand;

   assign fstart = iFVAL & ~fval_q;
   assign fend   = ~iFVAL & fval_q;
   assign pix    = iFVAL & iDVAL;

   seq_divider #(
      .N_W (SUM_W),
      .D_W (CNT_W)
   ) u_div (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iSTART    (div_start),
      .iNUM      (sum_q),
      .iDEN      (cnt_q),
      .oDONE     (div_done),
      .oQUO      (quo)
   );

   // Mean plus sign-extended offset, saturated to pixel range.
   always_comb begin
      mean   = (|quo[SUM_W-1:PIX_W]) ? '1 : quo[PIX_W-1:0];
      cand_s = {{(CAND_W-PIX_W){1'b0}}, mean}
             + {{(CAND_W-OFF_W){iOFFSET[OFF_W-1]}}, iOFFSET};
      cand   = clamp_thr(cand_s);
   end

   // Frame FSM: accumulate, divide, then hand result over.
   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      div_start = 1'b0;
      cand_rdy  = 1'b0;
      if (fstart)
         ovf_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fstart) begin
               sum_d   = '0;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (fend) begin
               if (ovf_q || cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DIVIDE;
                  div_start = 1'b1;
               end
            end else if (pix && !ovf_q) begin
               if (&cnt_q) begin
                  ovf_d = 1'b1;
               end else begin
                  sum_d = sum_q + SUM_W'(iDATA);
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DIVIDE: begin
            if (div_done)
               state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            cand_rdy = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // Threshold output: manual load or auto result, blanking only.
   always_comb begin
      thr_d  = thr_q;
      vld_d  = 1'b0;
      pend_d = pend_q;
      pthr_d = pthr_q;
      if (!iMODE) begin
         pend_d = 1'b0;
         if (!iFVAL)
            thr_d = iMAN_THR;
      end else if (cand_rdy) begin
         if (!iFVAL) begin
            thr_d  = cand;
            vld_d  = 1'b1;
            pend_d = 1'b0;
         end else begin
            pend_d = 1'b1;
            pthr_d = cand;
         end
      end else if (pend_q && !iFVAL) begin
         thr_d  = pthr_q;
         vld_d  = 1'b1;
         pend_d = 1'b0;
      end
   end

   // State registers; iFVAL copy resets high so a live frame is skipped.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state_q <= ST_IDLE;
         fval_q  <= 1'b1;
         sum_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         thr_q   <= DEFAULT_THR;
         vld_q   <= 1'b0;
         pend_q  <= 1'b0;
         pthr_q  <= '0;
      end else begin
         state_q <= state_d;
         fval_q  <= iFVAL;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         thr_q   <= thr_d;
         vld_q   <= vld_d;
         pend_q  <= pend_d;
         pthr_q  <= pthr_d;
      end
   end

   assign oTHRESHOLD = thr_q;
   assign oTHR_VALID = vld_q;
   assign oBUSY      = (state_q == ST_DIVIDE) || (state_q == ST_UPDATE);
   assign oOVF       = ovf_q;

endmodule

// File: tb/tb_threshold_ctrl.sv
// Randomized bench for threshold_ctrl against a frame-level model.
// Two instances: default counter width and a 4-bit counter.
module tb_threshold_ctrl;

   localparam int LIM_A = (1 << 20) - 1;
   localparam int LIM_B = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fval, dval, mode;
   logic [11:0] data, man_thr;
   logic [9:0]  off_sig;

   logic [11:0] thr_a, thr_b;
   logic        vld_a, vld_b, busy_a, busy_b, ovf_a, ovf_b;

   int n_tests = 0;
   int n_fail = 0;
   int exp_a, exp_b;
   int sum, cnt, off;
   int pix[$];

   always #5 clk = ~clk;

   threshold_ctrl u_dut_a (
      .iCLK (clk), .iRST (rst_n), .iFVAL (fval), .iDVAL (dval),
      .iDATA (data), .iMODE (mode), .iMAN_THR (man_thr),
      .iOFFSET (off_sig), .oTHRESHOLD (thr_a), .oTHR_VALID (vld_a),
      .oBUSY (busy_a), .oOVF (ovf_a)
   );

   threshold_ctrl #(.CNT_W (4)) u_dut_b (
      .iCLK (clk), .iRST (rst_n), .iFVAL (fval), .iDVAL (dval),
      .iDATA (data), .iMODE (mode), .iMAN_THR (man_thr),
      .iOFFSET (off_sig), .oTHRESHOLD (thr_b), .oTHR_VALID (vld_b),
      .oBUSY (busy_b), .oOVF (ovf_b)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hold(input string tag);
      chk({tag, "_thr_a"}, int'(thr_a), exp_a);
      chk({tag, "_thr_b"}, int'(thr_b), exp_b);
      chk({tag, "_vld_a"}, int'(vld_a), 0);
      chk({tag, "_vld_b"}, int'(vld_b), 0);
   endtask

   // Frame mean + offset, clamped; -1 when no result is produced.
   function automatic int model(input int lim, input int o);
      int m;
      if (cnt == 0 || cnt > lim)
         return -1;
      m = sum / cnt + o;
      if (m < 0) m = 0;
      if (m > 4095) m = 4095;
      return m;
   endfunction

   task automatic set_off(input int o);
      off = o;
      off_sig = 10'(o);
   endtask

   task automatic drive_frame();
      fval = 1'b1;
      dval = 1'b0;
      tick();
      chk("ovf_clr_a", int'(ovf_a), 0);
      chk("ovf_clr_b", int'(ovf_b), 0);
      chk_hold("start");
      sum = 0;
      cnt = 0;
      foreach (pix[i]) begin
         while ($urandom_range(0, 3) == 0) begin
            dval = 1'b0;
            data = 12'($urandom);
            tick();
            chk_hold("gap");
         end
         dval = 1'b1;
         data = 12'(pix[i]);
         tick();
         chk_hold("pix");
         sum += pix[i];
         cnt++;
      end
      dval = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_hold("tail");
      end
      fval = 1'b0;
   endtask

   task automatic settle();
      int ca, cb;
      ca = model(LIM_A, off);
      cb = model(LIM_B, off);
      for (int k = 0; k <= 36; k++) begin
         tick();
         if (k == 0) begin
            chk("ovf_a", int'(ovf_a), int'(cnt > LIM_A));
            chk("ovf_b", int'(ovf_b), int'(cnt > LIM_B));
         end
         chk("busy_a", int'(busy_a), int'(ca >= 0 && k <= 33));
         chk("busy_b", int'(busy_b), int'(cb >= 0 && k <= 33));
         chk("vld_a", int'(vld_a), int'(mode && ca >= 0 && k == 34));
         chk("vld_b", int'(vld_b), int'(mode && cb >= 0 && k == 34));
         chk("thr_a", int'(thr_a), (mode && ca >= 0 && k >= 34) ? ca : exp_a);
         chk("thr_b", int'(thr_b), (mode && cb >= 0 && k >= 34) ? cb : exp_b);
         dval = 1'($urandom_range(0, 1));
         data = 12'($urandom);
      end
      dval = 1'b0;
      if (mode && ca >= 0) exp_a = ca;
      if (mode && cb >= 0) exp_b = cb;
   endtask

   task automatic fill_rand(input int n);
      pix.delete();
      for (int i = 0; i < n; i++)
         pix.push_back(int'($urandom_range(0, 4095)));
   endtask

   initial begin
      int ca, cb;
      rst_n = 1'b0;
      fval = 1'b0;
      dval = 1'b0;
      data = '0;
      mode = 1'b1;
      man_thr = '0;
      set_off(0);
      tick(); tick(); tick();
      exp_a = 3747;
      exp_b = 3747;
      chk_hold("rst");
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_ovf", int'(ovf_a), 0);
      rst_n = 1'b1;
      tick();

      // 16 pixels of 2000, offset 0
      pix.delete();
      for (int i = 0; i < 16; i++) pix.push_back(2000);
      drive_frame();
      settle();
      chk("mean2000", exp_a, 2000);

      // clamp high and low
      pix.delete();
      for (int i = 0; i < 16; i++) pix.push_back((i % 2) ? 4090 : 4000);
      set_off(100);
      drive_frame();
      settle();
      pix.delete();
      for (int i = 0; i < 8; i++) pix.push_back(30);
      set_off(-100);
      drive_frame();
      settle();

      // frame with no pixels
      pix.delete();
      drive_frame();
      settle();

      // 20 pixels overflow the 4-bit counter only
      pix.delete();
      for (int i = 0; i < 20; i++) pix.push_back(1000);
      set_off(0);
      drive_frame();
      settle();

      // random frames
      for (int f = 0; f < 25; f++) begin
         fill_rand(int'($urandom_range(1, 20)));
         set_off(int'($urandom_range(0, 1023)) - 512);
         drive_frame();
         settle();
      end

      // next frame starts 10 cycles after frame end
      fill_rand(int'($urandom_range(1, 15)));
      set_off(int'($urandom_range(0, 1023)) - 512);
      drive_frame();
      ca = model(LIM_A, off);
      cb = model(LIM_B, off);
      for (int k = 0; k <= 70; k++) begin
         tick();
         chk("rs_busy_a", int'(busy_a), int'(k <= 33));
         chk("rs_busy_b", int'(busy_b), int'(k <= 33));
         chk("rs_vld_a", int'(vld_a), int'(k == 46));
         chk("rs_vld_b", int'(vld_b), int'(k == 46));
         chk("rs_thr_a", int'(thr_a), (k >= 46) ? ca : exp_a);
         chk("rs_thr_b", int'(thr_b), (k >= 46) ? cb : exp_b);
         fval = (k >= 9 && k <= 44);
         dval = 1'($urandom_range(0, 1));
         data = 12'($urandom);
      end
      dval = 1'b0;
      exp_a = ca;
      exp_b = cb;

      // reset in the middle of the division
      fill_rand(10);
      drive_frame();
      for (int k = 0; k <= 14; k++) begin
         tick();
         chk("md_busy_a", int'(busy_a), 1);
         chk_hold("md");
      end
      rst_n = 1'b0;
      tick();
      exp_a = 3747;
      exp_b = 3747;
      chk_hold("mdrst");
      chk("mdrst_busy_a", int'(busy_a), 0);
      chk("mdrst_busy_b", int'(busy_b), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("post_busy", int'(busy_a), 0);
         chk_hold("post");
      end

      // reset release inside a live frame: not measured
      fval = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         dval = 1'b1;
         data = 12'($urandom);
         tick();
      end
      dval = 1'b0;
      fval = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("live_busy", int'(busy_a), 0);
         chk_hold("live");
      end
      fill_rand(6);
      drive_frame();
      settle();

      // manual mode, then back to auto
      mode = 1'b0;
      man_thr = 12'd1234;
      tick();
      exp_a = 1234;
      exp_b = 1234;
      chk_hold("man");
      fill_rand(8);
      drive_frame();
      settle();
      mode = 1'b1;
      pix.delete();
      drive_frame();
      settle();
      chk("man_hold", exp_a, 1234);
      fill_rand(9);
      drive_frame();
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1);
   end

endmodule
